// File: rtl/mesm6_alu_pkg.sv
// mesm6_alu_pkg: macro-op codes, sequencer states and typed ALU uop constants.
`include "mesm6_defines.sv"

package mesm6_alu_pkg;

  localparam int unsigned WORD_W    = 48;
  localparam int unsigned MOP_W     = 3;
  localparam int unsigned ALU_OP_W  = `ALU_OP_WIDTH;
  localparam int unsigned MAX_STEPS = 2;
  localparam int unsigned STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  typedef enum logic [MOP_W-1:0] {
    AAX = 3'd0,
    AOX = 3'd1,
    AEX = 3'd2,
    ARX = 3'd3,
    ASX = 3'd4,
    ACX = 3'd5
  } mop_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t UOP_NOP              = alu_op_t'(`ALU_NOP);
  localparam alu_op_t UOP_AND              = alu_op_t'(`ALU_AND);
  localparam alu_op_t UOP_OR               = alu_op_t'(`ALU_OR);
  localparam alu_op_t UOP_XOR              = alu_op_t'(`ALU_XOR);
  localparam alu_op_t UOP_ADD_CARRY_AROUND = alu_op_t'(`ALU_ADD_CARRY_AROUND);
  localparam alu_op_t UOP_SHIFT            = alu_op_t'(`ALU_SHIFT);
  localparam alu_op_t UOP_COUNT            = alu_op_t'(`ALU_COUNT);

endpackage

// File: rtl/mesm6_alu_seq_if.sv
// mesm6_alu_seq_if: decode-side request and response handshake of the ALU sequencer.
interface mesm6_alu_seq_if;
  import mesm6_alu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [MOP_W-1:0]  req_mop;
  logic [WORD_W-1:0] req_a;
  logic [WORD_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_result;
  logic [WORD_W-1:0] rsp_y;
  logic              rsp_err;

  modport master (
    output req_valid, req_mop, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_y, rsp_err
  );

  modport slave (
    input  req_valid, req_mop, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_y, rsp_err
  );

endinterface

// File: rtl/mesm6_alu_seq_rom.sv
// mesm6_alu_seq_rom: combinational (mop, step) -> (uop, last, valid) micro-op table.
module mesm6_alu_seq_rom
  import mesm6_alu_pkg::*;
(
  input  logic [MOP_W-1:0]  mop,
  input  logic [STEP_W-1:0] step,
  output alu_op_t           uop_c,
  output logic              last_c,
  output logic              valid_c
);

  always_comb begin
    uop_c   = UOP_NOP;
    last_c  = 1'b1;
    valid_c = 1'b0;
    case (mop)
      AAX: begin uop_c = UOP_AND;              valid_c = 1'b1; end
      AOX: begin uop_c = UOP_OR;               valid_c = 1'b1; end
      AEX: begin uop_c = UOP_XOR;              valid_c = 1'b1; end
      ARX: begin uop_c = UOP_ADD_CARRY_AROUND; valid_c = 1'b1; end
      ASX: begin uop_c = UOP_SHIFT;            valid_c = 1'b1; end
      // Popcount of A, then end-around add of that count to B.
      ACX: begin
        valid_c = 1'b1;
        if (step == '0) begin
          uop_c  = UOP_COUNT;
          last_c = 1'b0;
        end else begin
          uop_c  = UOP_ADD_CARRY_AROUND;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mesm6_defines.sv
// mesm6_defines.sv: ALU micro-op encodings shared by the mesm6 ALU and its sequencer.
`ifndef MESM6_DEFINES_SV
`define MESM6_DEFINES_SV

`define ALU_OP_WIDTH          3
`define ALU_NOP               3'd0
`define ALU_AND               3'd1
`define ALU_OR                3'd2
`define ALU_XOR               3'd3
`define ALU_ADD_CARRY_AROUND  3'd4
`define ALU_SHIFT             3'd5
`define ALU_COUNT             3'd6

`endif

// File: rtl/mesm6_alu_seq.sv
// mesm6_alu_seq: issues ALU micro-op sequences for decoded macro-ops, one request at a time.
// Optional EXEC watchdog enabled by defining MESM6_ALU_SEQ_TIMEOUT_EN.
module mesm6_alu_seq
  import mesm6_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  mesm6_alu_seq_if.slave    bus,
  output alu_op_t           alu_op,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] alu_y,
  input  logic              alu_done
);

`ifdef MESM6_ALU_SEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 15;
  localparam int unsigned TMO_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  logic [TMO_W-1:0] tmo_cnt;
`endif

  seq_state_t        state;
  logic [MOP_W-1:0]  mop_q;
  logic [WORD_W-1:0] b_q;
  logic [STEP_W-1:0] step;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [WORD_W-1:0] rsp_result_q;
  logic [WORD_W-1:0] rsp_y_q;

  logic [MOP_W-1:0]  rom_mop;
  logic [STEP_W-1:0] rom_step;
  alu_op_t           rom_uop;
  logic              rom_last;
  logic              rom_valid;

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_y      = rsp_y_q;

  // Table lookup: first step of the incoming mop in IDLE, the next step while draining.
  always_comb begin
    rom_mop  = mop_q;
    rom_step = step;
    if (state == IDLE) begin
      rom_mop  = bus.req_mop;
      rom_step = '0;
    end else if (state == DRAIN) begin
      rom_step = STEP_W'(step + 1'b1);
    end
  end

  mesm6_alu_seq_rom u_rom (
    .mop     (rom_mop),
    .step    (rom_step),
    .uop_c   (rom_uop),
    .last_c  (rom_last),
    .valid_c (rom_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mop_q        <= '0;
      b_q          <= '0;
      step         <= '0;
      alu_op       <= UOP_NOP;
      alu_a        <= '0;
      alu_b        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      rsp_y_q      <= '0;
`ifdef MESM6_ALU_SEQ_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            mop_q       <= bus.req_mop;
            b_q         <= bus.req_b;
            alu_a       <= bus.req_a;
            alu_b       <= bus.req_b;
            step        <= '0;
            req_ready_q <= 1'b0;
`ifdef MESM6_ALU_SEQ_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
            if (rom_valid) begin
              alu_op <= rom_uop;
              state  <= EXEC;
            end else begin
              // Undefined mop: answer with an error, the ALU is never touched.
              rsp_result_q <= '0;
              rsp_y_q      <= '0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state        <= RESP;
            end
          end
        end

        EXEC: begin
          if (alu_done) begin
            rsp_result_q <= alu_result;
            rsp_y_q      <= alu_y;
            alu_op       <= UOP_NOP;
            if (rom_last) begin
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              state <= DRAIN;
            end
          end
`ifdef MESM6_ALU_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            alu_op       <= UOP_NOP;
            rsp_result_q <= '0;
            rsp_y_q      <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state        <= RESP;
          end else begin
            tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
          end
`endif
        end

        // One NOP cycle lets the ALU drop done before the chained uop starts.
        DRAIN: begin
          alu_a  <= rsp_result_q;
          alu_b  <= b_q;
          alu_op <= rom_uop;
          step   <= STEP_W'(step + 1'b1);
`ifdef MESM6_ALU_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state  <= EXEC;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// tb_mesm6_alu_seq: directed self-checking bench for mesm6_alu_seq with a behavioural ALU stand-in.
module tb_mesm6_alu_seq;
  import mesm6_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  alu_op_t     alu_op;
  logic [47:0] alu_a;
  logic [47:0] alu_b;
  logic [47:0] alu_result = '0;
  logic [47:0] alu_y      = '0;
  logic        alu_done   = 1'b1;   // stale done: the ALU has no reset
  logic        alu_stall  = 1'b0;
  int          alu_cnt    = 0;

  int checks = 0;
  int errors = 0;

  mesm6_alu_seq_if bus();

  mesm6_alu_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_y      (alu_y),
    .alu_done   (alu_done)
  );

  always #5 clk = ~clk;

  // ALU stand-in: ADD_CARRY_AROUND takes 2 cycles, everything else 1; NOP clears done.
  function automatic logic [47:0] calc_res(input alu_op_t op, input logic [47:0] a, input logic [47:0] b);
    logic [48:0] s;
    logic [5:0]  n;
    n = b[46:41];
    s = {1'b0, a} + {1'b0, b};
    case (op)
      UOP_AND:              return a & b;
      UOP_OR:               return a | b;
      UOP_XOR:              return a ^ b;
      UOP_ADD_CARRY_AROUND: return s[47:0] + 48'(s[48]);
      UOP_SHIFT:            return b[47] ? (a >> n) : (a << n);
      UOP_COUNT:            return 48'($countones(a));
      default:              return '0;
    endcase
  endfunction

  function automatic logic [47:0] calc_y(input alu_op_t op, input logic [47:0] a, input logic [47:0] b);
    logic [5:0] n;
    n = b[46:41];
    if (op == UOP_SHIFT && n != 6'd0)
      return b[47] ? (a << (7'd48 - 7'(n))) : (a >> (7'd48 - 7'(n)));
    return '0;
  endfunction

  always @(posedge clk) begin
    if (alu_op == UOP_NOP) begin
      alu_done <= 1'b0;
      alu_cnt  <= 0;
    end else if (!alu_done && !alu_stall) begin
      if (alu_cnt + 1 >= ((alu_op == UOP_ADD_CARRY_AROUND) ? 2 : 1)) begin
        alu_done   <= 1'b1;
        alu_result <= calc_res(alu_op, alu_a, alu_b);
        alu_y      <= calc_y(alu_op, alu_a, alu_b);
      end else begin
        alu_cnt <= alu_cnt + 1;
      end
    end
  end

  // Drive one request; returns #1 after the accept edge.
  task automatic send(input logic [2:0] mop, input logic [47:0] a, input logic [47:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mop   = mop;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Cycles until rsp_valid is seen (-1 if it never comes within the budget).
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (alu_op !== UOP_NOP) begin errors++; $display("FAIL reset_alu_op: got %0d expected %0d", alu_op, UOP_NOP); end
    checks++; if (alu_a !== 48'd0 || alu_b !== 48'd0) begin errors++; $display("FAIL reset_alu_ab: got a=%h b=%h expected 0", alu_a, alu_b); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags: got valid=%b err=%b expected 0 0", bus.rsp_valid, bus.rsp_err); end
    checks++; if (bus.rsp_result !== 48'd0 || bus.rsp_y !== 48'd0) begin errors++; $display("FAIL reset_rsp_data: got %h %h expected 0 0", bus.rsp_result, bus.rsp_y); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (alu_op !== UOP_NOP || bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_after_reset: got op=%0d ready=%b expected 0 1", alu_op, bus.req_ready); end
  endtask

  task automatic test_aax();
    int lat;
    send(3'(AAX), 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00);
    checks++; if (alu_op !== UOP_AND) begin errors++; $display("FAIL aax_issue_op: got %0d expected %0d", alu_op, UOP_AND); end
    checks++; if (alu_a !== 48'hF0F0_F0F0_F0F0 || alu_b !== 48'hFF00_FF00_FF00) begin errors++; $display("FAIL aax_operands: got a=%h b=%h expected f0f0f0f0f0f0 ff00ff00ff00", alu_a, alu_b); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL aax_busy_ready: got %b expected 0", bus.req_ready); end
    wait_rsp(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL aax_latency: got %0d expected 2", lat); end
    checks++; if (bus.rsp_result !== 48'hF000_F000_F000 || bus.rsp_y !== 48'd0) begin errors++; $display("FAIL aax_result: got %h y=%h expected f000f000f000 y=0", bus.rsp_result, bus.rsp_y); end
    checks++; if (alu_op !== UOP_NOP || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL aax_nop_err: got op=%0d err=%b expected 0 0", alu_op, bus.rsp_err); end
    consume();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL aax_release: got valid=%b ready=%b expected 0 1", bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_arx();
    int lat;
    send(3'(ARX), 48'hFFFF_FFFF_FFFF, 48'd1);
    wait_rsp(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL arx_latency: got %0d expected 3", lat); end
    checks++; if (bus.rsp_result !== 48'd1) begin errors++; $display("FAIL arx_result: got %h expected 1", bus.rsp_result); end
    consume();
  endtask

  task automatic test_acx();
    alu_op_t     exp_seq [7];
    alu_op_t     seen    [7];
    logic        valid5;
    logic [47:0] a3;
    logic [47:0] b3;
    exp_seq = '{UOP_COUNT, UOP_COUNT, UOP_NOP, UOP_ADD_CARRY_AROUND,
                UOP_ADD_CARRY_AROUND, UOP_ADD_CARRY_AROUND, UOP_NOP};
    valid5 = 1'b1;
    a3 = '0;
    b3 = '0;
    send(3'(ACX), 48'h0000_0000_00FF, 48'd5);
    seen[0] = alu_op;
    for (int i = 1; i < 7; i++) begin
      @(posedge clk); #1;
      seen[i] = alu_op;
      if (i == 3) begin a3 = alu_a; b3 = alu_b; end
      if (i == 5) valid5 = bus.rsp_valid;
    end
    for (int i = 0; i < 7; i++) begin
      checks++; if (seen[i] !== exp_seq[i]) begin errors++; $display("FAIL acx_uop_seq[%0d]: got %0d expected %0d", i, seen[i], exp_seq[i]); end
    end
    checks++; if (a3 !== 48'd8 || b3 !== 48'd5) begin errors++; $display("FAIL acx_chain_operands: got a=%h b=%h expected 8 5", a3, b3); end
    checks++; if (valid5 !== 1'b0 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL acx_latency: got valid@5=%b valid@6=%b expected 0 1", valid5, bus.rsp_valid); end
    checks++; if (bus.rsp_result !== 48'd13 || bus.rsp_y !== 48'd0) begin errors++; $display("FAIL acx_result: got %h y=%h expected d y=0", bus.rsp_result, bus.rsp_y); end
    consume();
  endtask

  task automatic test_shift();
    int lat;
    send(3'(ASX), 48'h0000_0000_0100, {1'b1, 6'd4, 41'd0});
    checks++; if (alu_op !== UOP_SHIFT) begin errors++; $display("FAIL asx_issue_op: got %0d expected %0d", alu_op, UOP_SHIFT); end
    wait_rsp(lat);
    checks++; if (lat !== 2 || bus.rsp_result !== 48'h10 || bus.rsp_y !== 48'd0) begin errors++; $display("FAIL asx_right: got lat=%0d %h y=%h expected 2 10 y=0", lat, bus.rsp_result, bus.rsp_y); end
    consume();
    send(3'(ASX), 48'h0000_0000_010F, {1'b1, 6'd4, 41'd0});
    wait_rsp(lat);
    checks++; if (bus.rsp_result !== 48'h10 || bus.rsp_y !== 48'hF000_0000_0000) begin errors++; $display("FAIL asx_right_y: got %h y=%h expected 10 y=f00000000000", bus.rsp_result, bus.rsp_y); end
    consume();
    send(3'(ASX), 48'h0000_0000_00AB, {1'b0, 6'd8, 41'd0});
    wait_rsp(lat);
    checks++; if (bus.rsp_result !== 48'h0000_0000_AB00) begin errors++; $display("FAIL asx_left: got %h expected ab00", bus.rsp_result); end
    consume();
  endtask

  task automatic test_undef();
    logic stable;
    send(3'd7, 48'h1234, 48'h5678);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin errors++; $display("FAIL undef7_flags: got valid=%b err=%b expected 1 1", bus.rsp_valid, bus.rsp_err); end
    checks++; if (bus.rsp_result !== 48'd0 || bus.rsp_y !== 48'd0) begin errors++; $display("FAIL undef7_data: got %h %h expected 0 0", bus.rsp_result, bus.rsp_y); end
    checks++; if (alu_op !== UOP_NOP) begin errors++; $display("FAIL undef7_alu_op: got %0d expected 0", alu_op); end
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.req_ready !== 1'b0 ||
          alu_op !== UOP_NOP || bus.rsp_result !== 48'd0) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL undef7_hold: got stable=%b expected 1", stable); end
    consume();
    checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL undef7_clear: got err=%b valid=%b expected 0 0", bus.rsp_err, bus.rsp_valid); end
    send(3'd6, 48'h1, 48'h2);
    checks++; if (bus.rsp_err !== 1'b1 || alu_op !== UOP_NOP) begin errors++; $display("FAIL undef6: got err=%b op=%0d expected 1 0", bus.rsp_err, alu_op); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(3'(AOX), 48'h0000_0000_0F0F, 48'h0000_0000_F000);
    wait_rsp(lat);
    checks++; if (bus.rsp_result !== 48'h0000_0000_FF0F) begin errors++; $display("FAIL aox_result: got %h expected ff0f", bus.rsp_result); end
    // Next request already pending while the response is held.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mop   = 3'(AEX);
    bus.req_a     = 48'h0FF0_0FF0_0FF0;
    bus.req_b     = 48'h00FF_00FF_00FF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b0 || bus.rsp_result !== 48'h0000_0000_FF0F) begin errors++; $display("FAIL b2b_hold: got ready=%b %h expected 0 ff0f", bus.req_ready, bus.rsp_result); end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++; if (alu_op !== UOP_NOP || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_release: got op=%0d ready=%b valid=%b expected 0 1 0", alu_op, bus.req_ready, bus.rsp_valid); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (alu_op !== UOP_XOR) begin errors++; $display("FAIL b2b_accept: got %0d expected %0d", alu_op, UOP_XOR); end
    wait_rsp(lat);
    checks++; if (lat !== 2 || bus.rsp_result !== 48'h0F0F_0F0F_0F0F) begin errors++; $display("FAIL aex_result: got lat=%0d %h expected 2 0f0f0f0f0f0f", lat, bus.rsp_result); end
    consume();
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic any_valid;
    send(3'(ACX), 48'h0000_0000_00FF, 48'd5);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (alu_op !== UOP_NOP || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_async: got op=%0d ready=%b valid=%b expected 0 1 0", alu_op, bus.req_ready, bus.rsp_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    any_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || alu_op !== UOP_NOP) any_valid = 1'b1;
    end
    checks++; if (any_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_rsp: got activity=%b expected 0", any_valid); end
    send(3'(AEX), 48'h0FF0_0FF0_0FF0, 48'h00FF_00FF_00FF);
    wait_rsp(lat);
    checks++; if (lat !== 2 || bus.rsp_result !== 48'h0F0F_0F0F_0F0F || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL midreset_next: got lat=%0d %h err=%b expected 2 0f0f0f0f0f0f 0", lat, bus.rsp_result, bus.rsp_err); end
    consume();
  endtask

`ifdef MESM6_ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    alu_stall = 1'b1;
    send(3'(AAX), 48'hFFFF, 48'hFFFF);
    wait_rsp(lat);
    checks++; if (lat !== 15) begin errors++; $display("FAIL timeout_latency: got %0d expected 15", lat); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_result !== 48'd0 || bus.rsp_y !== 48'd0 || alu_op !== UOP_NOP) begin errors++; $display("FAIL timeout_rsp: got err=%b %h %h op=%0d expected 1 0 0 0", bus.rsp_err, bus.rsp_result, bus.rsp_y, alu_op); end
    alu_stall = 1'b0;
    consume();
  endtask
`else
  task automatic test_timeout();
    int   lat;
    logic waited;
    alu_stall = 1'b1;
    send(3'(AAX), 48'hFFFF, 48'h0FF0);
    waited = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || alu_op !== UOP_AND) waited = 1'b0;
    end
    checks++; if (waited !== 1'b1) begin errors++; $display("FAIL stall_wait: got waited=%b expected 1", waited); end
    @(negedge clk);
    alu_stall = 1'b0;
    wait_rsp(lat);
    checks++; if (lat !== 2 || bus.rsp_result !== 48'h0FF0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL stall_release: got lat=%0d %h err=%b expected 2 0ff0 0", lat, bus.rsp_result, bus.rsp_err); end
    consume();
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_mop   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_aax();
    test_arx();
    test_acx();
    test_shift();
    test_undef();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesm6_alu_seq.md
Name: mesm6_alu_seq

Overview:
Sequencer sitting between instruction decode and the mesm6 ALU. It accepts one macro-operation (AAX, AOX, AEX, ARX, ASX/ASN, ACX) per valid/ready handshake and issues the matching ALU micro-op sequence. It honours the ALU protocol: the op is held until done, and the op returns to NOP to clear done. It chains multi-uop instructions (ACX = COUNT then ADD_CARRY_AROUND) and returns result/y on a valid/ready response port.

Parameters:
TIMEOUT_CYCLES, 15, maximum EXEC cycles per uop before abort (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  macro-op request valid
req_ready  output  1  sequencer can accept a request; high only in IDLE
req_mop  input  3  macro-op code (mop_t)
req_a  input  48  operand A (accumulator)
req_b  input  48  operand B (memory word, or shift descriptor for ASX/ASN)
alu_op  output  `ALU_OP_WIDTH  registered ALU op; NOP when idle
alu_a  output  48  registered ALU operand A
alu_b  output  48  registered ALU operand B
alu_result  input  48  ALU result
alu_y  input  48  ALU low-bits output
alu_done  input  1  ALU operation finished
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_result  output  48  final result
rsp_y  output  48  final y
rsp_err  output  1  undefined mop code or timeout

Behaviour:
- Reset (async, reset_n low): state IDLE; alu_op=NOP; alu_a, alu_b, rsp_result, rsp_y = 0; rsp_valid=0; rsp_err=0; step=0.
- Clock must run at least one cycle while alu_op=NOP after reset. This clears a stale ALU done, because the ALU has no reset.
- States: IDLE, EXEC, DRAIN, RESP.
- IDLE: req_ready=1. When req_valid is high, latch mop and b, and set alu_a=req_a and alu_b=req_b.
  - Valid mop: alu_op = ROM(mop, 0), go to EXEC.
  - Undefined mop (6, 7): go to RESP with rsp_err=1, result/y=0, no ALU activity.
- EXEC: alu_op held stable. When alu_done is seen, capture alu_result into rsp_result and alu_y into rsp_y, and set alu_op=NOP.
  - Step is last: go to RESP.
  - Otherwise: go to DRAIN.
- DRAIN: exactly one cycle with alu_op=NOP, so the ALU clears done and count. At the end of this cycle:
  - alu_a = captured result, alu_b = latched b, alu_op = ROM(mop, step+1), step++.
  - Go to EXEC.
- RESP: rsp_valid=1, outputs stable until rsp_ready. On rsp_ready, go to IDLE and clear rsp_valid/rsp_err. A new request is accepted no earlier than the following cycle.
- Mop → uop map:
  - AAX→AND, AOX→OR, AEX→XOR, ARX→ADD_CARRY_AROUND, ASX→SHIFT (single step each).
  - ACX→COUNT then ADD_CARRY_AROUND.
- Latency from accept edge to rsp_valid high: 2 cycles for single-cycle uops, 3 for ARX, 6 for ACX.
- alu_done is sampled only in EXEC. It is ignored in IDLE, DRAIN and RESP.
- Async reset mid-EXEC: sequencer returns to IDLE immediately. Any in-flight result is discarded and no response is produced.

Optional Feature:
MESM6_ALU_SEQ_TIMEOUT_EN
- Defined: a 4-bit+ cycle counter is cleared on EXEC entry and counts EXEC cycles. When it reaches TIMEOUT_CYCLES without alu_done:
  - alu_op=NOP, rsp_result=rsp_y=0, rsp_err=1.
  - Go to RESP.
- Undefined: no counter; EXEC waits for alu_done indefinitely. rsp_err is driven only by undefined mops.

Decomposition:
- Package mesm6_alu_pkg holds:
  - typedef enum mop_t: AAX=0, AOX=1, AEX=2, ARX=3, ASX=4, ACX=5.
  - typedef enum seq_state_t.
  - Constant MAX_STEPS=2.
- ALU uop codes remain in mesm6_defines.sv.
- One sub-module, mesm6_alu_seq_rom: combinational map (mop, step) → (uop, last, valid).

Test Plan:
- AAX, a=48'hF0F0_F0F0_F0F0, b=48'hFF00_FF00_FF00 → rsp_result=48'hF000_F000_F000, y=0, rsp_valid 2 cycles after accept, alu_op back to NOP.
- ARX, a=48'hFFFF_FFFF_FFFF, b=1 → carry wraps around, rsp_result=1, latency 3.
- ACX, a=48'h0000_0000_00FF, b=5 → popcount 8 plus 5, rsp_result=13; exactly one NOP cycle between COUNT and ADD_CARRY_AROUND.
- ASX right shift: b[47]=1, b[46:41]=4, a=48'h100 → rsp_result=48'h10.
- Undefined mop 7 → rsp_err=1, result 0, alu_op never leaves NOP. rsp_ready held low 5 cycles → response stable, req_ready low.
- reset_n pulsed low during ACX EXEC → alu_op=NOP and req_ready=1 immediately, no rsp_valid. Next AEX completes with a correct result. With the timeout feature and alu_done tied 0 → rsp_err after 15 EXEC cycles.
